// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and bridge state type.
//   HTRANS_*  transfer type codes
//   HSIZE_*   transfer size codes (byte/half/word)
//   HRESP_*   response codes
//   bridge_state_t  bridge FSM states
//   lane_mask()     byte-lane enables for a sub-word store
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    IDLE, RD, RD_DATA, WR, RMW_RD, RMW_WR, ERR1, ERR2
  } bridge_state_t;

  function automatic logic [3:0] lane_mask(input logic [1:0] offset, input logic [2:0] size);
    case (size)
      HSIZE_BYTE: lane_mask = 4'b0001 << offset;
      HSIZE_HALF: lane_mask = offset[1] ? 4'b1100 : 4'b0011;
      default:    lane_mask = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_byte_merge.sv
// Combinational byte-lane merge for read-modify-write stores.
//   old_word_i  word read back from SRAM
//   new_word_i  lane-aligned AHB write data
//   offset_i    byte offset (addr[1:0])
//   size_i      HSIZE of the store
//   merged_o    old word with the addressed lanes replaced by new data
module ahb_byte_merge
  import ahb_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  size_i,
  output logic [31:0] merged_o
);

  logic [3:0] mask;

  always_comb begin
    mask     = lane_mask(offset_i, size_i);
    merged_o = old_word_i;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) merged_o[8*b +: 8] = new_word_i[8*b +: 8];
    end
  end

endmodule

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave in front of a word-only SRAM.
//   HCLK/HRESET        clock, async active-high reset
//   HSEL..HREADY       AHB address/data phase inputs
//   HRDATA/HREADYOUT/HRESP  AHB slave response
//   sram_*             SRAM command port; reads are implied whenever
//                      sram_write_enable=0 and sram_ready=1
// Sub-word stores become a read (RMW_RD) followed by a merged write (RMW_WR).
module ahb_sram_bridge
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        sram_write_enable,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic        sram_ready,
  input  logic [31:0] sram_read_data
);

  bridge_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [2:0]    size_q, size_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   old_q, old_d;
  logic          first_q, first_d;

  logic          accept;
  logic          addr_err;
  logic [31:0]   merge_old;
  logic [31:0]   merged;

  assign accept   = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign addr_err = (HSIZE > HSIZE_WORD)
                 || (HSIZE == HSIZE_HALF && HADDR[0])
                 || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00)
                 || (HADDR >= 32'(MEM_BYTES));

  // Read data is only guaranteed on the first RMW_WR cycle; keep a copy
  // in case the SRAM stalls the write.
  assign merge_old    = first_q ? sram_read_data : old_q;
  assign sram_address = {addr_q[31:2], 2'b00};

  ahb_byte_merge u_merge (
    .old_word_i (merge_old),
    .new_word_i (wdata_q),
    .offset_i   (addr_q[1:0]),
    .size_i     (size_q),
    .merged_o   (merged)
  );

  always_comb begin
    state_d           = state_q;
    addr_d            = addr_q;
    size_d            = size_q;
    wdata_d           = wdata_q;
    old_d             = old_q;
    first_d           = 1'b0;
    HREADYOUT         = 1'b1;
    HRESP             = HRESP_OKAY;
    HRDATA            = '0;
    sram_write_enable = 1'b0;
    sram_write_data   = '0;

    case (state_q)
      IDLE: ;
      RD: begin
        HREADYOUT = 1'b0;
        if (sram_ready) state_d = RD_DATA;
      end
      RD_DATA: HRDATA = sram_read_data;
      WR: begin
        sram_write_enable = 1'b1;
        sram_write_data   = HWDATA;
        HREADYOUT         = sram_ready;
      end
      RMW_RD: begin
        HREADYOUT = 1'b0;
        wdata_d   = HWDATA;
        if (sram_ready) begin
          state_d = RMW_WR;
          first_d = 1'b1;
        end
      end
      RMW_WR: begin
        sram_write_enable = 1'b1;
        sram_write_data   = merged;
        HREADYOUT         = sram_ready;
        if (first_q) old_d = sram_read_data;
      end
      ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ERR2;
      end
      ERR2: HRESP = HRESP_ERROR;
      default: state_d = IDLE;
    endcase

    // Last cycle of the current transfer: pick up the next address phase.
    if (HREADYOUT) begin
      state_d = IDLE;
      if (accept) begin
        addr_d = HADDR;
        size_d = HSIZE;
        if (addr_err)                 state_d = ERR1;
        else if (!HWRITE)             state_d = RD;
        else if (HSIZE == HSIZE_WORD) state_d = WR;
        else                          state_d = RMW_RD;
      end
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
module tb_ahb_sram_bridge;
  import ahb_pkg::*;

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hreadyout;
  logic        hresp;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wd;
  logic        sram_ready;
  logic [31:0] sram_rd;

  int tests  = 0;
  int failed = 0;

  logic [31:0] mem [0:1023];
  int          wr_count  = 0;
  int          we_cycles = 0;
  logic [31:0] last_wr   = '0;

  always #5 clk = ~clk;

  ahb_sram_bridge #(.MEM_BYTES(4096)) dut (
    .HCLK              (clk),
    .HRESET            (hreset),
    .HSEL              (hsel),
    .HADDR             (haddr),
    .HTRANS            (htrans),
    .HWRITE            (hwrite),
    .HSIZE             (hsize),
    .HWDATA            (hwdata),
    .HREADY            (hreadyout),
    .HRDATA            (hrdata),
    .HREADYOUT         (hreadyout),
    .HRESP             (hresp),
    .sram_write_enable (sram_we),
    .sram_address      (sram_addr),
    .sram_write_data   (sram_wd),
    .sram_ready        (sram_ready),
    .sram_read_data    (sram_rd)
  );

  // SRAM model: registered read, one-cycle latency, stallable
  always @(posedge clk) begin
    if (sram_we) we_cycles <= we_cycles + 1;
    if (sram_ready) begin
      if (sram_we) begin
        mem[sram_addr[11:2]] <= sram_wd;
        wr_count             <= wr_count + 1;
        last_wr              <= sram_wd;
      end else begin
        sram_rd <= mem[sram_addr[11:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    htrans = HTRANS_IDLE;
    haddr  = '0;
    hwrite = 1'b0;
    hsize  = '0;
  endtask

  // One non-pipelined transfer; starts and ends just after a rising edge.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [2:0] sz,
                      input logic [31:0] wd, input int stall,
                      output int waits, output logic [31:0] rd,
                      output logic r_first, output logic r_last);
    bit done;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = a; hwrite = w; hsize = sz;
    @(posedge clk); #1;
    bus_idle();
    hwdata     = wd;
    sram_ready = (stall == 0);
    waits = 0; rd = '0; r_first = 1'b0; r_last = 1'b0; done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (k == 0) r_first = hresp;
      if (hreadyout) begin
        r_last = hresp;
        rd     = hrdata;
        done   = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #1;
      if (waits == stall) sram_ready = 1'b1;
    end
    if (!done) check("xfer_timeout", {31'd0, hreadyout}, 32'd1);
    @(posedge clk); #1;
    sram_ready = 1'b1;
  endtask

  int          w;
  logic [31:0] rd;
  logic        rf, rl;
  int          wc0, we0;
  bit          got;

  initial begin
    hreset = 1'b1; sram_ready = 1'b1; hwdata = '0;
    bus_idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    check("rst_hresp",     {31'd0, hresp},     32'd0);
    check("rst_hrdata",    hrdata,             32'd0);
    check("rst_we",        {31'd0, sram_we},   32'd0);
    check("rst_addr",      sram_addr,          32'd0);
    check("rst_wdata",     sram_wd,            32'd0);
    hreset = 1'b0;
    @(posedge clk); #1;

    // BUSY while selected: zero-wait OKAY, no SRAM write
    we0 = we_cycles;
    hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge clk); #1;
    bus_idle();
    @(negedge clk);
    check("busy_ready", {31'd0, hreadyout}, 32'd1);
    check("busy_resp",  {31'd0, hresp},     32'd0);
    @(posedge clk); #1;
    check("busy_no_we", we_cycles, we0);

    // 1: word write then read
    xfer(32'h10, 1'b1, HSIZE_WORD, 32'hDEADBEEF, 0, w, rd, rf, rl);
    check("t1_wr_waits", w, 0);
    check("t1_wr_resp",  {31'd0, rl}, 32'd0);
    xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 0, w, rd, rf, rl);
    check("t1_rd_waits", w, 1);
    check("t1_rd_data",  rd, 32'hDEADBEEF);
    check("t1_rd_resp",  {31'd0, rl}, 32'd0);

    // 2: byte store into 0x11223344
    xfer(32'h10, 1'b1, HSIZE_WORD, 32'h11223344, 0, w, rd, rf, rl);
    wc0 = wr_count; we0 = we_cycles;
    xfer(32'h12, 1'b1, HSIZE_BYTE, 32'h00AB0000, 0, w, rd, rf, rl);
    check("t2_waits",   w, 1);
    check("t2_nwr",     wr_count - wc0, 1);
    check("t2_we_cyc",  we_cycles - we0, 1);
    check("t2_merged",  last_wr, 32'h11AB3344);
    xfer(32'h10, 1'b0, HSIZE_WORD, 32'h0, 0, w, rd, rf, rl);
    check("t2_readback", rd, 32'h11AB3344);

    // 3: error responses
    we0 = we_cycles;
    xfer(32'h13, 1'b1, HSIZE_HALF, 32'hFFFF0000, 0, w, rd, rf, rl);
    check("t3_half_err1", {31'd0, rf}, 32'd1);
    check("t3_half_wait", w, 1);
    check("t3_half_err2", {31'd0, rl}, 32'd1);
    xfer(32'h1000, 1'b0, HSIZE_WORD, 32'h0, 0, w, rd, rf, rl);
    check("t3_oor_err1", {31'd0, rf}, 32'd1);
    check("t3_oor_wait", w, 1);
    check("t3_oor_err2", {31'd0, rl}, 32'd1);
    xfer(32'h0, 1'b1, 3'd3, 32'h0, 0, w, rd, rf, rl);
    check("t3_size_err", {31'd0, rl}, 32'd1);
    xfer(32'h2, 1'b1, HSIZE_WORD, 32'h0, 0, w, rd, rf, rl);
    check("t3_word_misalign", {31'd0, rl}, 32'd1);
    check("t3_no_we", we_cycles, we0);
    // last in-range word is fine
    xfer(32'hFFC, 1'b1, HSIZE_WORD, 32'hCAFEF00D, 0, w, rd, rf, rl);
    check("t3_top_wr_resp", {31'd0, rl}, 32'd0);
    xfer(32'hFFC, 1'b0, HSIZE_WORD, 32'h0, 0, w, rd, rf, rl);
    check("t3_top_rd", rd, 32'hCAFEF00D);

    // 4: pipelined write then read of the same word
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h20; hwrite = 1'b1; hsize = HSIZE_WORD;
    @(posedge clk); #1;
    hwdata = 32'h55; hwrite = 1'b0;
    @(negedge clk);
    check("t4_wr_ready", {31'd0, hreadyout}, 32'd1);
    @(posedge clk); #1;
    bus_idle();
    w = 0; got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (hreadyout) begin got = 1'b1; break; end
      w++;
      @(posedge clk); #1;
    end
    check("t4_rd_done",  {31'd0, got}, 32'd1);
    check("t4_rd_waits", w, 1);
    check("t4_rd_data",  hrdata, 32'h55);
    @(posedge clk); #1;

    // 5: SRAM stalls for 3 cycles in RMW_RD
    wc0 = wr_count; we0 = we_cycles;
    xfer(32'h21, 1'b1, HSIZE_BYTE, 32'h00007700, 3, w, rd, rf, rl);
    check("t5_waits",  w, 4);
    check("t5_nwr",    wr_count - wc0, 1);
    check("t5_we_cyc", we_cycles - we0, 1);
    check("t5_merged", last_wr, 32'h00007755);
    xfer(32'h20, 1'b0, HSIZE_WORD, 32'h0, 0, w, rd, rf, rl);
    check("t5_readback", rd, 32'h00007755);

    // 6: reset while RMW_WR waits on the SRAM
    xfer(32'h30, 1'b1, HSIZE_WORD, 32'hA5A5A5A5, 0, w, rd, rf, rl);
    wc0 = wr_count;
    hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h30; hwrite = 1'b1; hsize = HSIZE_BYTE;
    @(posedge clk); #1;
    bus_idle();
    hwdata = 32'hFF;
    @(posedge clk); #1;
    sram_ready = 1'b0;
    @(negedge clk);
    check("t6_we_before",  {31'd0, sram_we},   32'd1);
    check("t6_rdy_before", {31'd0, hreadyout}, 32'd0);
    #1 hreset = 1'b1;
    #1;
    check("t6_we_rst",  {31'd0, sram_we},   32'd0);
    check("t6_rdy_rst", {31'd0, hreadyout}, 32'd1);
    check("t6_resp_rst", {31'd0, hresp},    32'd0);
    @(posedge clk); #1;
    sram_ready = 1'b1;
    @(posedge clk); #1;
    hreset = 1'b0;
    check("t6_no_write", wr_count, wc0);
    xfer(32'h30, 1'b0, HSIZE_WORD, 32'h0, 0, w, rd, rf, rl);
    check("t6_unchanged", rd, 32'hA5A5A5A5);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
